fpu_issue_ctrl: RTL and testbench

- Sequences the shared single-issue FPU datapath.
- Accepts one decoded FP op per handshake (4-bit fpucontrol code plus writeback info) and holds it in a latch while the FPU runs.
- Counts a per-op latency, stalls the core pipeline while busy, and emits a one-cycle writeback strobe with destination and register-file select.
- Sits between the decode stage (fpudec outputs) and the FPU/regfile writeback mux.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/fpu_lat_lut.sv | 29 ++
 rtl/fpu_issue_ctrl.sv | 87 ++++++++
 tb/tb_fpu_issue_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: fpucontrol opcode constants and issue-controller state type
package fpu_pkg;

    localparam logic [3:0] FPU_ADD  = 4'b0000;
    localparam logic [3:0] FPU_SUB  = 4'b0001;
    localparam logic [3:0] FPU_MUL  = 4'b0010;
    localparam logic [3:0] FPU_DIV  = 4'b0011;
    localparam logic [3:0] FPU_SQRT = 4'b0100;
    localparam logic [3:0] FPU_FTOI = 4'b0101;
    localparam logic [3:0] FPU_FEQ  = 4'b0110;
    localparam logic [3:0] FPU_FLT  = 4'b0111;
    localparam logic [3:0] FPU_FLE  = 4'b1000;
    localparam logic [3:0] FPU_ITOF = 4'b1001;

    typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/fpu_lat_lut.sv
// fpu_lat_lut: maps an fpucontrol code to its latency and a legal flag; illegal codes get latency 1
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 10,
    parameter int LAT_SQRT = 10,
    parameter int LAT_CVT  = 1,
    parameter int LAT_CMP  = 1
) (
    input  logic [3:0] code,
    output logic [4:0] lat,
    output logic       legal
);

    // latency selection per opcode group
    always_comb begin
        legal = code <= FPU_ITOF;
        lat = (code == FPU_ADD || code == FPU_SUB)                    ? 5'(LAT_ADD)  :
              (code == FPU_MUL)                                       ? 5'(LAT_MUL)  :
              (code == FPU_DIV)                                       ? 5'(LAT_DIV)  :
              (code == FPU_SQRT)                                      ? 5'(LAT_SQRT) :
              (code == FPU_FTOI || code == FPU_ITOF)                  ? 5'(LAT_CVT)  :
              (code == FPU_FEQ || code == FPU_FLT || code == FPU_FLE) ? 5'(LAT_CMP)  :
                                                                        5'd1;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue FPU sequencer (latency count, stall, writeback strobe); FPU_B2B_ISSUE_EN enables back-to-back issue
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 10,
    parameter int LAT_SQRT = 10,
    parameter int LAT_CVT  = 1,
    parameter int LAT_CMP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [3:0] issue_ctrl,
    input  logic       issue_fregwb,
    input  logic [4:0] issue_rd,
    input  logic       flush,
    output logic       issue_stall,
    output logic       busy,
    output logic       fpu_start,
    output logic [3:0] fpu_ctrl,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_fregwb,
    output logic       illegal_op
);

    state_t     state;
    logic [4:0] cnt;
    logic [4:0] lat;
    logic       legal;
    logic       op_legal;
    logic       accept;

    fpu_lat_lut #(
        .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
        .LAT_SQRT(LAT_SQRT), .LAT_CVT(LAT_CVT), .LAT_CMP(LAT_CMP)
    ) u_lut (
        .code(issue_ctrl),
        .lat(lat),
        .legal(legal)
    );

    // handshake, stall and writeback strobe; flush always wins over issue and writeback
    always_comb begin
`ifdef FPU_B2B_ISSUE_EN
        accept = issue_valid && !flush && (state == IDLE || (state == BUSY && cnt == 5'd0));
`else
        accept = issue_valid && !flush && state == IDLE;
`endif
        issue_stall = issue_valid && !flush && !accept;
        busy = state == BUSY;
        wb_valid = state == BUSY && cnt == 5'd0 && !flush && op_legal;
    end

    // state, latency counter, op latches and one-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 5'd0;
            fpu_start <= 1'b0;
            illegal_op <= 1'b0;
            fpu_ctrl <= 4'd0;
            wb_rd <= 5'd0;
            wb_fregwb <= 1'b0;
            op_legal <= 1'b0;
        end else begin
            fpu_start <= accept;
            illegal_op <= accept && !legal;
            if (accept) begin
                state <= BUSY;
                cnt <= lat - 5'd1;
                fpu_ctrl <= issue_ctrl;
                wb_rd <= issue_rd;
                wb_fregwb <= issue_fregwb;
                op_legal <= legal;
            end else if (state == BUSY && (flush || cnt == 5'd0)) begin
                state <= IDLE;
                cnt <= 5'd0;
            end else if (cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: schedule-based reference model, directed scenarios and random traffic for fpu_issue_ctrl
module tb_fpu_issue_ctrl;

    logic       clk = 0;
    logic       reset = 1;
    logic       issue_valid = 0;
    logic [3:0] issue_ctrl = 0;
    logic       issue_fregwb = 0;
    logic [4:0] issue_rd = 0;
    logic       flush = 0;
    logic       issue_stall, busy, fpu_start, wb_valid, wb_fregwb, illegal_op;
    logic [3:0] fpu_ctrl;
    logic [4:0] wb_rd;

    int total = 0;
    int bad = 0;

    fpu_issue_ctrl dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ctrl(issue_ctrl),
        .issue_fregwb(issue_fregwb), .issue_rd(issue_rd), .flush(flush),
        .issue_stall(issue_stall), .busy(busy), .fpu_start(fpu_start), .fpu_ctrl(fpu_ctrl),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fregwb(wb_fregwb), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // reference model: one op in flight, described by the cycles it starts and ends
    int cyc = 0;
    bit have_op = 0;
    int op_start, op_end;
    bit op_legal;
    bit ill_next = 0;
    int m_ctrl = 0, m_rd = 0, m_fregwb = 0;
    bit m_accept;

    function automatic int lat_of(input int code);
        case (code)
            0, 1: return 2;
            2: return 2;
            3: return 10;
            4: return 10;
            5, 9: return 1;
            6, 7, 8: return 1;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int code, input bit fr, input int rd, input bit fl, input bit rs);
        bit can;
        @(negedge clk);
        issue_valid = v;
        issue_ctrl = 4'(code);
        issue_fregwb = fr;
        issue_rd = 5'(rd);
        flush = fl;
        reset = rs;
        #1;
`ifdef FPU_B2B_ISSUE_EN
        can = !have_op || cyc == op_end;
`else
        can = !have_op;
`endif
        m_accept = v && !fl && can;
        chk("busy", busy, int'(have_op));
        chk("fpu_start", fpu_start, int'(have_op && cyc == op_start));
        chk("wb_valid", wb_valid, int'(have_op && cyc == op_end && op_legal && !fl));
        chk("issue_stall", issue_stall, int'(v && !fl && !m_accept));
        chk("illegal_op", illegal_op, int'(ill_next));
        chk("fpu_ctrl", fpu_ctrl, m_ctrl);
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_fregwb", wb_fregwb, m_fregwb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            have_op = 0;
            ill_next = 0;
            m_ctrl = 0; m_rd = 0; m_fregwb = 0;
        end else if (m_accept) begin
            have_op = 1;
            op_start = cyc + 1;
            op_end = cyc + lat_of(int'(issue_ctrl));
            op_legal = issue_ctrl <= 4'd9;
            ill_next = !op_legal;
            m_ctrl = int'(issue_ctrl); m_rd = int'(issue_rd); m_fregwb = int'(issue_fregwb);
        end else begin
            ill_next = 0;
            if (have_op && (flush || cyc == op_end)) have_op = 0;
        end
        cyc++;
    endtask

    task automatic step(input bit v, input int code, input bit fr, input int rd, input bit fl, input bit rs);
        drive(v, code, fr, rd, fl, rs);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    int nst;

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_ctrl", fpu_ctrl, 0);
        tick();

        // fadd rd=3
        drive(1, 0, 0, 3, 0, 0);
        chk("lit_fadd_stall", issue_stall, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_fadd_start", fpu_start, 1);
        chk("lit_fadd_busy1", busy, 1);
        chk("lit_fadd_nowb", wb_valid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_fadd_wb", wb_valid, 1);
        chk("lit_fadd_rd", wb_rd, 3);
        chk("lit_fadd_busy2", busy, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_fadd_done", busy, 0);
        tick();

        // fdiv then fmul held valid
        step(1, 3, 0, 4, 0, 0);
        nst = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 2, 0, 5, 0, 0);
            if (issue_stall) begin
                nst++;
                tick();
            end else begin
                tick();
                break;
            end
        end
`ifdef FPU_B2B_ISSUE_EN
        chk("lit_fdiv_stalls", nst, 9);
`else
        chk("lit_fdiv_stalls", nst, 10);
`endif
        idle(4);

        // feq rd=7 to integer regfile
        step(1, 6, 1, 7, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_feq_start", fpu_start, 1);
        chk("lit_feq_wb", wb_valid, 1);
        chk("lit_feq_fregwb", wb_fregwb, 1);
        chk("lit_feq_rd", wb_rd, 7);
        tick();
        idle(2);

        // fsqrt flushed at T+5, fadd at T+6
        step(1, 4, 0, 9, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 10, 0, 0);
        chk("lit_flush_busy", busy, 0);
        chk("lit_flush_stall", issue_stall, 0);
        tick();
        idle(4);

        // illegal code 1100
        step(1, 12, 0, 11, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_ill_pulse", illegal_op, 1);
        chk("lit_ill_nowb", wb_valid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("lit_ill_idle", busy, 0);
        tick();

        // reset at T+3 of fdiv
        step(1, 3, 1, 12, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 13, 0, 0);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_wb", wb_valid, 0);
        chk("lit_rst_ctrl", fpu_ctrl, 0);
        chk("lit_rst_stall", issue_stall, 0);
        tick();
        idle(3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
